alu_pipe: RTL

//   Parametrised 2-stage pipelined integer ALU; successor to the 4-bit FA4/Rsub4/twosComp set.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_pipe_adder.sv | 26 ++
 rtl/alu_pipe.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and width-dependent saturation limits for the alu_pipe slice.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OpAdd  = 3'b000,
        OpAddc = 3'b001,
        OpSub  = 3'b010,
        OpRsub = 3'b011,
        OpNeg  = 3'b100,
        OpAcc  = 3'b101,
        OpClr  = 3'b110,
        OpPass = 3'b111
    } op_e;

    // Largest positive two's complement value of the given width (0111..1).
    function automatic logic [31:0] sat_max(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    // Most negative two's complement value of the given width (1000..0).
    function automatic logic [31:0] sat_min(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/alu_pipe_adder.sv
// Parametrised ripple-carry adder (x + y + cin) with carry out and signed overflow.
module adder_nbit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

    assign ovf = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready integer ALU with flags, accumulator and sticky overflow.
// Define ALU_SAT_EN to clamp overflowing results instead of wrapping.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam logic [31:0] SatMax32 = sat_max(WIDTH);
    localparam logic [31:0] SatMin32 = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SatMax = SatMax32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SatMin = SatMin32[WIDTH-1:0];

    logic             s1_valid_q;
    op_e              s1_op_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] res_q;
    logic             c_q, v_q, z_q, n_q;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cf_q, cf_d;
    logic             sticky_q, sticky_d;

    logic             s2_load, accept;
    logic [WIDTH-1:0] x, y, sum, res_d;
    logic             cin, cout, ovf, c_d, v_d;

    assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_load;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OpAdd;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_op_q    <= op_e'(in_op);
            s1_a_q     <= in_a;
            s1_b_q     <= in_b;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Every op is mapped onto the single x + y + cin adder.
    always_comb begin
        x   = '0;
        y   = '0;
        cin = 1'b0;
        unique case (s1_op_q)
            OpAdd:  begin x = s1_a_q; y = s1_b_q; end
            OpAddc: begin x = s1_a_q; y = s1_b_q; cin = cf_q; end
            OpSub:  begin x = s1_a_q; y = ~s1_b_q; cin = 1'b1; end
            OpRsub: begin x = s1_b_q; y = ~s1_a_q; cin = 1'b1; end
            OpNeg:  begin x = '0; y = ~s1_a_q; cin = 1'b1; end
            OpAcc:  begin x = acc_q; y = s1_a_q; end
            OpClr, OpPass: ;
        endcase
    end

    adder_nbit #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a   (x),
        .b   (y),
        .cin (cin),
        .sum (sum),
        .cout(cout),
        .ovf (ovf)
    );

    always_comb begin
        res_d = sum;
        c_d   = cout;
        v_d   = ovf;
`ifdef ALU_SAT_EN
        // Operand signs agree on overflow, so x's sign gives the overflow direction.
        if (ovf) begin
            res_d = x[WIDTH-1] ? SatMin : SatMax;
        end
`endif
        case (s1_op_q)
            OpClr: begin
                res_d = '0;
                c_d   = 1'b0;
                v_d   = 1'b0;
            end
            OpPass: begin
                res_d = s1_a_q;
                c_d   = 1'b0;
                v_d   = 1'b0;
            end
            default: ;
        endcase

        acc_d = acc_q;
        cf_d  = cf_q;
        if (s2_load) begin
            if (s1_op_q != OpClr && s1_op_q != OpPass) begin
                cf_d = c_d;
            end
            if (s1_op_q == OpAcc) begin
                acc_d = res_d;
            end else if (s1_op_q == OpClr) begin
                acc_d = '0;
            end
        end
        sticky_d = (sticky_q & ~clr_sticky) | (s2_load & v_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            acc_q       <= '0;
            cf_q        <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid_q <= 1'b1;
                res_q       <= res_d;
                c_q         <= c_d;
                v_q         <= v_d;
                z_q         <= (res_d == '0);
                n_q         <= res_d[WIDTH-1];
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            acc_q    <= acc_d;
            cf_q     <= cf_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_res    = res_q;
    assign out_c      = c_q;
    assign out_v      = v_q;
    assign out_z      = z_q;
    assign out_n      = n_q;
    assign ovf_sticky = sticky_q;

endmodule
